apu_envelope_unit: RTL

- Volume envelope generator for the square and noise channels. It is the downstream consumer of the frame counter's quarter-frame strobe (nLFO1).
- Holds the channel's volume/period register fields, plus a start flag, a divider and a decay counter. Outputs the 4-bit volume that feeds the channel DAC.
- Also exports the loop bit, which serves as the length-counter halt.

---
 rtl/apu_envelope_unit.sv | 74 +++++++
 1 files changed

// File: rtl/apu_envelope_unit.sv
// Volume envelope generator for the APU square/noise channels, clocked by the quarter-frame strobe.
// Optional macro ENVELOPE_MUTE_EN adds n_LCZERO, which forces VOL to zero while the length counter is zero.
module apu_envelope_unit #(
  parameter int PERIOD_W = 4
) (
  input  logic                ACLK,
  input  logic                n_RES,
  input  logic                nLFO1,
  input  logic                W_REG,
  input  logic                W_RESTART,
  input  logic [5:0]          DB,
`ifdef ENVELOPE_MUTE_EN
  input  logic                n_LCZERO,
`endif
  output logic [PERIOD_W-1:0] VOL,
  output logic                LHALT
);

  localparam logic [PERIOD_W-1:0] DECAY_MAX = {PERIOD_W{1'b1}};

  logic [PERIOD_W-1:0] r_period;
  logic                r_cvol;
  logic                r_loop;
  logic                r_start;
  logic [PERIOD_W-1:0] r_divider;
  logic [PERIOD_W-1:0] r_decay;
  logic                w_tick;
  logic [PERIOD_W-1:0] w_vol;

  assign w_tick = ~nLFO1;

  always_ff @(posedge ACLK or negedge n_RES) begin
    if (!n_RES) begin
      r_period  <= '0;
      r_cvol    <= 1'b0;
      r_loop    <= 1'b0;
      r_start   <= 1'b0;
      r_divider <= '0;
      r_decay   <= '0;
    end else begin
      // The tick always works from pre-edge period/loop; a same-cycle write lands afterwards.
      if (w_tick) begin
        if (r_start) begin
          r_decay   <= DECAY_MAX;
          r_divider <= r_period;
        end else if (r_divider == '0) begin
          r_divider <= r_period;
          if (r_decay != '0)
            r_decay <= r_decay - 1'b1;
          else if (r_loop)
            r_decay <= DECAY_MAX;
        end else begin
          r_divider <= r_divider - 1'b1;
        end
      end
      r_start <= W_RESTART | (r_start & ~w_tick);
      if (W_REG) begin
        r_loop   <= DB[5];
        r_cvol   <= DB[4];
        r_period <= PERIOD_W'(DB[3:0]);
      end
    end
  end

  assign w_vol = r_cvol ? r_period : r_decay;

`ifdef ENVELOPE_MUTE_EN
  assign VOL = n_LCZERO ? w_vol : '0;
`else
  assign VOL = w_vol;
`endif
  assign LHALT = r_loop;

endmodule
